// File: rtl/ras_stack.sv
// ras_stack: return address stack for the fetch stage.
// Pushes call PC + 4 on a call, pops on a return, and presents the top entry
// as the predicted return target. A {cnt, tos} snapshot is exported so the
// branch unit can restore the speculative pointer state after a mispredict.
// Optional feature: define RAS_RECOVER_EN to enable pointer recovery from
// recover_ptr_i; without it recover_i / recover_ptr_i are ignored.

module ras_stack #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ras_valid_i,
   input  logic [1:0]        ras_ctrl_i,
   input  logic [63:0]       ras_data_i,
   output logic [63:0]       ras_top_o,
   output logic              ras_empty_o,
   output logic              ras_full_o,
   output logic [2*AW:0]     ras_ptr_o,
   input  logic              recover_i,
   input  logic [2*AW:0]     recover_ptr_i
);

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_SWAP = 2'b11   // pop-then-push (coroutine)
   } op_e;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] TOS_ONE  = AW'(1);

   // Stack storage and pointer state
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] tos;
   logic [AW:0]   cnt;

   // Next-state and write-port controls
   logic [AW-1:0] tos_next;
   logic [AW:0]   cnt_next;
   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [63:0]   push_value;
   logic          empty;
   logic          full;
   op_e           op;

   assign op         = op_e'(ras_ctrl_i);
   assign push_value = ras_data_i + 64'h4;
   assign empty      = (cnt == '0);
   assign full       = (cnt == CNT_FULL);

   // Decode the requested operation into pointer updates and one write.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case/if tree can leave a value unassigned and infer a latch.
      tos_next = tos;
      cnt_next = cnt;
      wr_en    = 1'b0;
      wr_idx   = tos;

      if (ras_valid_i) begin
         unique case (op)
            OP_PUSH: begin
               tos_next = tos + TOS_ONE;
               wr_en    = 1'b1;
               wr_idx   = tos + TOS_ONE;
               // A push into a full stack overwrites the oldest entry.
               cnt_next = full ? cnt : cnt + CNT_ONE;
            end
            OP_POP: begin
               // Popping an empty stack is a no-op; the stale top is kept.
               if (!empty) begin
                  tos_next = tos - TOS_ONE;
                  cnt_next = cnt - CNT_ONE;
               end
            end
            OP_SWAP: begin
               if (empty) begin
                  // Nothing to pop: identical to a plain push.
                  tos_next = tos + TOS_ONE;
                  wr_en    = 1'b1;
                  wr_idx   = tos + TOS_ONE;
                  cnt_next = cnt + CNT_ONE;
               end else begin
                  // Replace the top entry in place; depth is unchanged.
                  wr_en  = 1'b1;
                  wr_idx = tos;
               end
            end
            default: ;  // OP_NONE holds state
         endcase
      end

`ifdef RAS_RECOVER_EN
      // Recovery wins over any same-cycle operation, which is dropped.
      // Entry contents are deliberately not restored.
      if (recover_i) begin
         cnt_next = recover_ptr_i[2*AW:AW];
         tos_next = recover_ptr_i[AW-1:0];
         wr_en    = 1'b0;
      end
`endif
   end

`ifndef RAS_RECOVER_EN
   // Recovery ports exist for interface compatibility but drive nothing.
   logic unused_recover;
   assign unused_recover = ^{recover_i, recover_ptr_i};
`endif

   // Pointer registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: state is written with non-blocking assignments so every flop
      // samples the pre-edge values regardless of block evaluation order.
      if (rst_i) begin
         tos <= '0;
         cnt <= '0;
      end else begin
         tos <= tos_next;
         cnt <= cnt_next;
      end
   end

   // Entry storage; single write port driven by the decode above.
   always_ff @(posedge clk_i) begin
      // NOTE: the entries are reset because the top output after reset and
      // after an empty pop must read a defined value, which rules out RAM
      // macros and keeps this array in flops.
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= push_value;
      end
   end

   // Outputs depend only on registered state.
   assign ras_top_o   = mem[tos];
   assign ras_empty_o = empty;
   assign ras_full_o  = full;
   assign ras_ptr_o   = {cnt, tos};

endmodule

// File: doc/ras_stack.md
# ras_stack

Return address stack for the fetch stage. It is the consumer of the branch predecoder's RAS request: it pushes the return address (call PC + 4) on a call and pops on a return. It also presents the current top of stack back to the predecoder as the predicted return target. A pointer snapshot is exported so that the branch unit can restore speculative stack state after a misprediction.

## Interface
- `DEPTH`, default 8: number of entries; power of two, at least 2.
- `AW`, default `$clog2(DEPTH)`: entry index width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `ras_valid_i`  in  1  qualifies `ras_ctrl_i` and `ras_data_i`. Low during a fetch stall or override.
- `ras_ctrl_i`  in  2  operation:
  - 00 none
  - 01 push
  - 10 pop
  - 11 pop-then-push (coroutine)
- `ras_data_i`  in  64  PC of the call instruction.
- `ras_top_o`  out  64  current top-of-stack entry; drives the predecoder's return target.
- `ras_empty_o`  out  1  count == 0.
- `ras_full_o`  out  1  count == DEPTH.
- `ras_ptr_o`  out  2*AW+1  snapshot `{cnt[AW:0], tos[AW-1:0]}` of the current state.
- `recover_i`  in  1  restore the pointer state from `recover_ptr_i`.
- `recover_ptr_i`  in  2*AW+1  snapshot previously taken from `ras_ptr_o`.

## Operation
- Storage is a circular array `mem[DEPTH]` of 64 bits.
  - `tos` indexes the top entry.
  - `cnt` (AW+1 bits) counts valid entries and saturates at DEPTH.
- Push value is `ras_data_i + 64'h4`, computed modulo 2^64.
- Push (01):
  - `tos <= tos+1` (mod DEPTH) and `mem[tos+1] <= value`.
  - `cnt <= min(cnt+1, DEPTH)`.
  - When full, the push silently overwrites the oldest entry and `cnt` stays at DEPTH.
- Pop (10) with `cnt > 0`: `tos <= tos-1` (mod DEPTH), `cnt <= cnt-1`.
- Pop (10) with `cnt == 0`: no state change; `ras_top_o` remains the stale entry.
- Pop-then-push (11):
  - With `cnt > 0`: `mem[tos] <= value`; `tos` and `cnt` are unchanged.
  - With `cnt == 0`: behaves exactly as a push.
- When `ras_valid_i` is 0, or `ras_ctrl_i` is 00, the state holds.
- Recovery (when compiled in, see Configuration):
  - `recover_i=1` loads `{cnt,tos}` from `recover_ptr_i`.
  - It has priority over any same-cycle `ras_valid_i` operation; that operation is dropped.
  - Entry contents are not restored. Entries overwritten since the snapshot stay corrupted; this is accepted as a predictor inaccuracy.
- Output derivation:
  - `ras_top_o = mem[tos]`.
  - `ras_empty_o` and `ras_full_o` are decoded from `cnt`.
  - `ras_ptr_o = {cnt, tos}`.
  - All outputs are functions of registered state only; none has a combinational path from any input.

## Timing
- Reset values:
  - all `mem` entries 0, `tos=0`, `cnt=0`.
  - Therefore `ras_top_o=0`, `ras_empty_o=1`, `ras_full_o=0`, `ras_ptr_o=0`.
- Reset overrides `recover_i` and any operation in the same cycle.
- Latency: an operation sampled at edge N is visible on all outputs after edge N; it is usable by the predecoder in the next cycle.
- At most one operation is accepted per cycle; there is no backpressure.
- The `ras_ptr_o` sampled in the same cycle as a request reflects the state *before* that request. The branch unit stores it alongside the branch.
- Pointer wrap: `tos` increments from DEPTH-1 to 0 and decrements from 0 to DEPTH-1.

## Configuration
- Macro `RAS_RECOVER_EN`.
- Defined: recovery operates as described under Operation.
- Undefined:
  - `recover_i` and `recover_ptr_i` are present but ignored.
  - No recovery mux is synthesised.
  - `ras_ptr_o` still reflects the current state.

## Test plan
- Reset, then push with PCs 0x1000, 0x2000, 0x3000 → `ras_top_o=0x3004`. Then pop ×3 → `ras_top_o` reads 0x2004, then 0x1004; empty=1 after the third pop.
- DEPTH=8: push 9 times with PC=0x100·k (k=1..9) → full=1, top=0x904. Then pop 8 times → the last value read before empty is 0x204; 0x104 has been lost.
- Pop while empty → `ras_ptr_o` unchanged (0), `ras_empty_o=1`, `ras_top_o=0`.
- Push PC 0x40, then ctrl=11 with PC 0x80 → top=0x84, cnt remains 1. Ctrl=11 while empty with PC 0x80 → cnt=1, top=0x84.
- Snapshot `ras_ptr_o` after 2 pushes, push 2 more, then assert `recover_i` together with a valid push (with `RAS_RECOVER_EN`) → cnt=2 and tos as snapshotted; the push is dropped. Without the macro, the push takes effect (cnt=5).
- `ras_valid_i=0` with ctrl=01 → no change. Assert `rst_i` mid-sequence with cnt=3 → all outputs return to their reset values next cycle.
